muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_unit_div_step.sv | 30 +++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam int MUL_LAT_DEFAULT = 2;

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// rtl/muldiv_unit_div_step.sv - one combinational restoring-divide step (one quotient bit)
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // quo_i carries the not-yet-consumed dividend bits in its top end
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit; MULDIV_EARLY_OUT_EN enables divide early-out
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1;

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, a_q, a_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [2*WIDTH-1:0] pipe_q [MUL_LAT];
  logic [2*WIDTH-1:0] pipe_d [MUL_LAT];

  muldiv_op_t         op_e;
  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, step_rem, step_quo;
  logic [2*WIDTH-1:0] ext_a, ext_b;

  assign op_e = muldiv_op_t'(op);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    a_d       = a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    pipe_d[0] = pipe_q[0];
    for (int i = 1; i < MUL_LAT; i++) pipe_d[i] = pipe_q[i-1];

    sgn   = is_signed_op(op_e);
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};

    case (state_q)
      IDLE: if (start) begin
        case (op_e)
          OP_MULT, OP_MULTU: begin
            pipe_d[0] = ext_a * ext_b;
            cnt_d     = CNT_W'(MUL_LAT - 1);
            busy_d    = 1'b1;
            state_d   = MUL;
          end
          OP_DIV, OP_DIVU: begin
            a_d       = a;
            dvsr_d    = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = (b == '0);
            rem_d     = '0;
            quo_d     = a_mag;
            cnt_d     = CNT_W'(WIDTH - 1);
            busy_d    = 1'b1;
            state_d   = DIV;
`ifdef MULDIV_EARLY_OUT_EN
            // quotient is zero and remainder is |a|; FIX waits one cycle via cnt
            if ((b != '0) && (a_mag < b_mag)) begin
              rem_d   = a_mag;
              quo_d   = '0;
              cnt_d   = CNT_W'(1);
              state_d = FIX;
            end
`endif
          end
          OP_MTHI: hi_d = a;
          OP_MTLO: lo_d = a;
          default: ;
        endcase
      end
      MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = pipe_q[MUL_LAT-1];
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = neg_rem_q ? -rem_q : rem_q;
            lo_d = neg_quo_q ? -quo_q : quo_q;
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      a_q       <= a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      pipe_q    <= pipe_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (either MULDIV_EARLY_OUT_EN build)
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Call at a negedge; returns just after the accepting edge with operands scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0BAD_F00D;
  endtask

  // cyc = edges from the accepting edge to the edge that raised done; nb = busy cycles seen.
  task automatic wait_done(output int cyc, output int nb);
    cyc = 0; nb = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      if (done === 1'b1 || cyc >= 100) break;
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_assert++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
  endtask

  task automatic test_mult;
    int cyc, nb;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, nb);
    n_assert++; if (cyc !== 2) begin n_fail++; $display("FAIL mult_latency got %0d want 2", cyc); end
    n_assert++; if (nb !== 2) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 2", nb); end
    n_assert++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_result got %h want ffffffffffffffeb", {hi, lo}); end
    @(negedge clk);
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got %0b want 0", done); end
  endtask

  task automatic test_multu;
    int cyc, nb;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, nb);
    n_assert++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_result got %h want fffffffe00000001", {hi, lo}); end
  endtask

  task automatic test_div_signed;
    int cyc, nb;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, nb);
    n_assert++; if (cyc !== 33) begin n_fail++; $display("FAIL div_latency got %0d want 33", cyc); end
    n_assert++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_quot got %h want fffffffd", lo); end
    n_assert++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_rem got %h want ffffffff", hi); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, nb);
    n_assert++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow got %h want 0000000080000000", {hi, lo}); end
  endtask

  task automatic test_divu_zero;
    int cyc, nb;
    issue(3'd3, 32'd100, 32'd0);
    wait_done(cyc, nb);
    n_assert++; if (cyc !== 33) begin n_fail++; $display("FAIL divz_latency got %0d want 33", cyc); end
    n_assert++; if ({hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL divz_result got %h want 00000064ffffffff", {hi, lo}); end
  endtask

  task automatic test_busy_ignore;
    int cyc, nb;
    issue(3'd3, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %0b want 1", busy); end
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, nb);
    n_assert++; if (cyc !== 28) begin n_fail++; $display("FAIL ign_latency got %0d want 28", cyc); end
    n_assert++; if ({hi, lo} !== {32'd6, 32'd142}) begin n_fail++; $display("FAIL ign_result got %h want 000000060000008e", {hi, lo}); end
  endtask

  task automatic test_reset_abort;
    int seen;
    issue(3'd3, 32'd50, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", busy); end
    n_assert++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL abort_hilo got %h want 0", {hi, lo}); end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    n_assert++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_mthi_mtlo;
    issue(3'd4, 32'h0000_1234, 32'd0);
    @(negedge clk);
    n_assert++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_hi got %h want 00001234", hi); end
    n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_flags got busy=%0b done=%0b want 0 0", busy, done); end
    issue(3'd5, 32'hCAFE_0001, 32'd0);
    @(negedge clk);
    n_assert++; if ({hi, lo} !== 64'h0000_1234_CAFE_0001) begin n_fail++; $display("FAIL mtlo_hilo got %h want 00001234cafe0001", {hi, lo}); end
    issue(3'd6, 32'h1111_1111, 32'd2);
    @(negedge clk);
    n_assert++; if (busy !== 1'b0 || {hi, lo} !== 64'h0000_1234_CAFE_0001) begin n_fail++; $display("FAIL invalid_op got busy=%0b hilo=%h want 0 00001234cafe0001", busy, {hi, lo}); end
  endtask

  task automatic test_early_out;
    int cyc, nb, want;
`ifdef MULDIV_EARLY_OUT_EN
    want = 2;
`else
    want = 33;
`endif
    issue(3'd3, 32'd3, 32'd10);
    wait_done(cyc, nb);
    n_assert++; if (cyc !== want) begin n_fail++; $display("FAIL early_latency got %0d want %0d", cyc, want); end
    n_assert++; if ({hi, lo} !== {32'd3, 32'd0}) begin n_fail++; $display("FAIL early_result got %h want 0000000300000000", {hi, lo}); end
    issue(3'd2, 32'hFFFF_FFFD, 32'd10);
    wait_done(cyc, nb);
    n_assert++; if (cyc !== want) begin n_fail++; $display("FAIL early_s_latency got %0d want %0d", cyc, want); end
    n_assert++; if ({hi, lo} !== {32'hFFFF_FFFD, 32'd0}) begin n_fail++; $display("FAIL early_s_result got %h want fffffffd00000000", {hi, lo}); end
  endtask

  task automatic test_back_to_back;
    int cyc, nb;
    issue(3'd0, 32'd2, 32'd3);
    wait_done(cyc, nb);
    n_assert++; if ({hi, lo} !== 64'd6) begin n_fail++; $display("FAIL b2b_first got %h want 6", {hi, lo}); end
    issue(3'd1, 32'd6, 32'd7);
    wait_done(cyc, nb);
    n_assert++; if (cyc !== 2 || {hi, lo} !== 64'd42) begin n_fail++; $display("FAIL b2b_second got lat=%0d hilo=%h want 2 42", cyc, {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div_signed();
    test_divu_zero();
    test_busy_ignore();
    test_reset_abort();
    test_mthi_mtlo();
    test_early_out();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
